price_table_loader: RTL and testbench
=====================================

Name: price_table_loader

Overview:
- Writer side of the packed price table consumed by the price-selection logic.
- Accepts an operator byte stream over a valid/ready handshake: a product-number byte followed by a price byte.
- Validates both bytes, commits each price into a 10-entry register file and drives the packed `price_of_all` bus.
- Also supports a sequenced clear-all and a lock input that blocks reprogramming while vending is active.

Parameters:
- NUM_PRODUCTS, 10, number of table entries; product numbers run 1..NUM_PRODUCTS.
- PRICE_W, 8, width of one price.
- DEFAULT_PRICE, 8'd0, value written at reset and by clear-all.
- MAX_PRICE, 8'd200, largest legal price; larger values are rejected.
- TIMEOUT, 16, idle cycles allowed between the product byte and the price byte.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the byte on in_data is offered.
- in_data  in  8  product byte or price byte, depending on state.
- in_ready  out  1  byte accepted on a clock edge where in_valid && in_ready.
- clear_all  in  1  request to reset every entry to DEFAULT_PRICE.
- lock  in  1  vending active; blocks commits and clears.
- price_of_all  out  NUM_PRODUCTS*PRICE_W  packed table; product k occupies bits [8k-1:8k-8].
- table_updated  out  1  one-cycle pulse after an entry commit or after a clear completes.
- err  out  1  one-cycle pulse on a rejected byte, a lock violation or a timeout.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (rst high at an edge):
  - All entries load DEFAULT_PRICE; the state goes to S_PROD.
  - table_updated, err, busy and the counters go to 0.
  - Reset mid-clear or mid-transaction abandons it with no commit.
- States:
  - S_PROD: expecting the product byte.
  - S_PRICE: product captured, expecting the price byte.
  - S_CLEAR: walking the entries.
- in_ready = (state != S_CLEAR) && !clear_all. It is combinational from state and clear_all only.
- S_PROD, on accept:
  - Legal means in_data[7:4]==0 and 1 <= in_data[3:0] <= NUM_PRODUCTS.
  - Legal byte: capture the index (in_data-1), clear the timeout counter, go to S_PRICE.
  - Illegal byte (0, 11..255): err pulse, stay in S_PROD.
- S_PRICE, on accept:
  - Price > MAX_PRICE: err pulse, no commit, back to S_PROD.
  - lock high: err pulse, no commit, back to S_PROD.
  - Otherwise: write the entry, pulse table_updated, go to S_PROD.
  - The new value is visible on price_of_all in the cycle after the accepting edge, the same cycle as the pulse.
  - Only the addressed entry changes; the other 72 bits stay stable.
- S_PRICE timeout:
  - The counter increments on every edge without an accept.
  - At TIMEOUT consecutive idle cycles: err pulse, back to S_PROD, captured product discarded.
  - An accept on the final idle edge wins over the timeout.
- clear_all:
  - Sampled in S_PROD or S_PRICE when lock is low.
  - It has priority over a simultaneous in_valid; no byte is accepted that edge because in_ready is low.
  - Any pending product is abandoned. Enter S_CLEAR with index 0 and busy high.
  - One entry is written per cycle, so the clear takes NUM_PRODUCTS cycles.
  - After index NUM_PRODUCTS-1: table_updated pulse, busy low, back to S_PROD.
  - clear_all while in S_CLEAR is ignored.
  - clear_all with lock high: err pulse, no state change.
- lock does not gate in_ready; product bytes are still validated normally while lock is high.
- err and table_updated are never high in the same cycle.
- price_of_all is fully registered with no combinational path from the inputs.

Decomposition:
- Shared package vend_pkg holds:
  - NUM_PRODUCTS, PRICE_W, MAX_PRICE, DEFAULT_PRICE;
  - product-code constants PROD_MIN=1 and PROD_MAX=10;
  - the loader state enum {S_PROD, S_PRICE, S_CLEAR}.
- One sub-module, price_entry_file:
  - NUM_PRODUCTS x PRICE_W registers with a single write port (we, idx, data) and synchronous reset to DEFAULT_PRICE;
  - drives the packed output;
  - the FSM and the timeout/clear counters stay in the top level.

Test Plan:
- Reset, then send 0x03 then 0x2D → bits [23:16]=0x2D one cycle after the second accept, one table_updated pulse, all other bytes 0.
- Send product 0x0B, then 0x00, then 0x13 → err pulse on each, state stays S_PROD, table unchanged.
- Send 0x05, then price 0xC9 (above 200) → err, no commit; then send 0x05 and 0xC8 → bits [39:32]=0xC8.
- Send 0x07, then hold in_valid low for 16 cycles → err on the 16th idle edge. Then send 0x50 alone → treated as a product byte → err (illegal product).
- Program entries 1 and 10, then assert clear_all together with in_valid → byte not accepted, busy high for 10 cycles, table all 0x00, table_updated after the last write.
- Hold lock high, send 0x02 then 0x10 → err, entry 2 unchanged. Assert clear_all with lock high → err, busy stays low. Assert rst during S_CLEAR → table = DEFAULT_PRICE and state S_PROD on the next cycle.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared constants, state encoding and product-code check for the vending price table.
package vend_pkg;

  localparam int NUM_PRODUCTS = 10;
  localparam int PRICE_W      = 8;
  localparam int IDX_W        = 4;
  localparam int TIMEOUT      = 16;
  localparam int TMO_W        = 5;

  localparam logic [PRICE_W-1:0] MAX_PRICE     = 8'd200;
  localparam logic [PRICE_W-1:0] DEFAULT_PRICE = 8'd0;
  localparam logic [3:0]         PROD_MIN      = 4'd1;
  localparam logic [3:0]         PROD_MAX      = 4'd10;

  typedef enum logic [1:0] {
    S_PROD  = 2'd0,
    S_PRICE = 2'd1,
    S_CLEAR = 2'd2
  } load_state_e;

  function automatic logic is_legal_product(input logic [7:0] b);
    return (b[7:4] == 4'd0) && (b[3:0] >= PROD_MIN) && (b[3:0] <= PROD_MAX);
  endfunction

endpackage

// File: rtl/price_entry_file.sv
// Register file of product prices with one write port and a packed read-out bus.
module price_entry_file
  import vend_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we_i,
  input  logic [IDX_W-1:0]                  idx_i,
  input  logic [PRICE_W-1:0]                data_i,
  output logic [NUM_PRODUCTS*PRICE_W-1:0]   price_of_all_o
);

  logic [PRICE_W-1:0] entry_q [NUM_PRODUCTS];

  // Entry storage: reset to the default price, otherwise only the addressed entry moves.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (rst) begin
        entry_q[i] <= DEFAULT_PRICE;
      end else if (we_i && (idx_i == IDX_W'(i))) begin
        entry_q[i] <= data_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_pack
    assign price_of_all_o[g*PRICE_W +: PRICE_W] = entry_q[g];
  end

endmodule

// File: rtl/price_table_loader.sv
// Operator byte-stream front end: validates product/price pairs, runs the timed
// price wait and the one-entry-per-cycle clear walk, and owns the price register file.
module price_table_loader
  import vend_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [7:0]                        in_data,
  output logic                              in_ready,
  input  logic                              clear_all,
  input  logic                              lock,
  output logic [NUM_PRODUCTS*PRICE_W-1:0]   price_of_all,
  output logic                              table_updated,
  output logic                              err,
  output logic                              busy
);

  load_state_e        state_q, state_d;
  logic [IDX_W-1:0]   prod_idx_q, prod_idx_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               upd_q, upd_d;
  logic               err_q, err_d;
  logic               busy_q;
  logic               accept_s;
  logic               we_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [PRICE_W-1:0] wr_data_s;

  assign in_ready = (state_q != S_CLEAR) && !clear_all;
  assign accept_s = in_valid && in_ready;

  // Next-state, write-port and pulse decode.
  always_comb begin
    state_d    = state_q;
    prod_idx_d = prod_idx_q;
    clr_idx_d  = clr_idx_q;
    tmo_d      = tmo_q;
    upd_d      = 1'b0;
    err_d      = 1'b0;
    we_s       = 1'b0;
    wr_idx_s   = prod_idx_q;
    wr_data_s  = in_data;
    case (state_q)
      S_PROD: begin
        if (clear_all) begin
          if (lock) begin
            err_d = 1'b1;
          end else begin
            state_d   = S_CLEAR;
            clr_idx_d = {IDX_W{1'b0}};
          end
        end else if (accept_s) begin
          if (is_legal_product(in_data)) begin
            prod_idx_d = in_data[3:0] - 4'd1;
            tmo_d      = {TMO_W{1'b0}};
            state_d    = S_PRICE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_PROD;
        end
      end
      S_PRICE: begin
        if (clear_all && !lock) begin
          state_d   = S_CLEAR;
          clr_idx_d = {IDX_W{1'b0}};
        end else if (accept_s) begin
          state_d = S_PROD;
          if ((in_data > MAX_PRICE) || lock) begin
            err_d = 1'b1;
          end else begin
            we_s  = 1'b1;
            upd_d = 1'b1;
          end
        end else begin
          // Idle edge; a locked clear request still counts as idle for the timeout.
          err_d = clear_all;
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_PROD;
          end else begin
            tmo_d = tmo_q + 5'd1;
          end
        end
      end
      S_CLEAR: begin
        we_s      = 1'b1;
        wr_idx_s  = clr_idx_q;
        wr_data_s = DEFAULT_PRICE;
        if (clr_idx_q == IDX_W'(NUM_PRODUCTS - 1)) begin
          upd_d     = 1'b1;
          clr_idx_d = {IDX_W{1'b0}};
          state_d   = S_PROD;
        end else begin
          clr_idx_d = clr_idx_q + 4'd1;
        end
      end
      default: begin
        state_d = S_PROD;
      end
    endcase
  end

  // Control state, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PROD;
      prod_idx_q <= {IDX_W{1'b0}};
      clr_idx_q  <= {IDX_W{1'b0}};
      tmo_q      <= {TMO_W{1'b0}};
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prod_idx_q <= prod_idx_d;
      clr_idx_q  <= clr_idx_d;
      tmo_q      <= tmo_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      busy_q     <= (state_d == S_CLEAR);
    end
  end

  assign table_updated = upd_q;
  assign err           = err_q;
  assign busy          = busy_q;

  price_entry_file u_entries (
    .clk            (clk),
    .rst            (rst),
    .we_i           (we_s),
    .idx_i          (wr_idx_s),
    .data_i         (wr_data_s),
    .price_of_all_o (price_of_all)
  );

endmodule

// File: tb/tb_price_table_loader.sv
// Randomized + directed bench: a transaction-level table model predicts every
// err/table_updated pulse into a queue that an independent monitor drains.
module tb_price_table_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clear_all;
  logic        lock;
  logic [79:0] price_of_all;
  logic        table_updated;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  price_table_loader dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .clear_all     (clear_all),
    .lock          (lock),
    .price_of_all  (price_of_all),
    .table_updated (table_updated),
    .err           (err),
    .busy          (busy)
  );

  typedef struct {
    bit          is_err;
    logic [79:0] tbl;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model: prices, the pending product (-1 = none), idle count, entries left to clear.
  int m_tbl [10];
  int pend      = -1;
  int idle_cnt  = 0;
  int clr_left  = 0;

  function automatic logic [79:0] pack_tbl();
    logic [79:0] v;
    for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(m_tbl[i]);
    return v;
  endfunction

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_ev(input bit is_err);
    ev_t e;
    e.is_err = is_err;
    e.tbl    = pack_tbl();
    exp_q.push_back(e);
  endtask

  // Predict the effect of one clock edge given the inputs presented for it.
  task automatic model_edge(input bit r, input bit v, input logic [7:0] d, input bit c, input bit l);
    if (r) begin
      for (int i = 0; i < 10; i++) m_tbl[i] = 0;
      pend = -1; idle_cnt = 0; clr_left = 0;
      return;
    end
    if (clr_left > 0) begin
      m_tbl[10 - clr_left] = 0;
      clr_left--;
      if (clr_left == 0) push_ev(1'b0);
      return;
    end
    if (c && !l) begin
      pend = -1;
      clr_left = 10;
      return;
    end
    if (c) begin
      if (pend >= 0) begin
        idle_cnt++;
        if (idle_cnt == 16) pend = -1;
      end
      push_ev(1'b1);
    end else if (v) begin
      if (pend < 0) begin
        if (d >= 8'd1 && d <= 8'd10) begin
          pend = int'(d) - 1;
          idle_cnt = 0;
        end else begin
          push_ev(1'b1);
        end
      end else begin
        if (d > 8'd200 || l) begin
          push_ev(1'b1);
        end else begin
          m_tbl[pend] = int'(d);
          push_ev(1'b0);
        end
        pend = -1;
      end
    end else if (pend >= 0) begin
      idle_cnt++;
      if (idle_cnt == 16) begin
        pend = -1;
        push_ev(1'b1);
      end
    end
  endtask

  // Monitor: every pulse the DUT shows is matched against the next predicted event.
  always @(negedge clk) begin
    if (err === 1'b1 && table_updated === 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL pulse_overlap: got err=1 table_updated=1 expected at most one");
    end else if (err === 1'b1 || table_updated === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pulse: got err=%0b upd=%0b expected none", err, table_updated);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_kind_err", {79'd0, err}, {79'd0, e.is_err});
        check("pulse_table", price_of_all, e.tbl);
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit c, input bit l);
    bit exp_rdy;
    rst = r; in_valid = v; in_data = d; clear_all = c; lock = l;
    exp_rdy = (clr_left == 0) && !c;
    #1;
    if (!r) check("in_ready", {79'd0, in_ready}, {79'd0, exp_rdy});
    model_edge(r, v, d, c, l);
    @(posedge clk);
    #1;
    check("busy", {79'd0, busy}, {79'd0, (clr_left > 0)});
  endtask

  task automatic idle(input int n, input bit l);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    bit lk;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_table", price_of_all, 80'd0);
    check("reset_flags", {77'd0, err, table_updated, busy}, 80'd0);

    // Basic commit to product 3.
    cyc(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h2D, 1'b0, 1'b0);
    check("commit_p3_direct", price_of_all, 80'h00_00_00_00_00_00_00_2D_00_00);
    idle(2, 1'b0);

    // Illegal product bytes.
    cyc(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h13, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("illegal_table", price_of_all, pack_tbl());

    // Price boundary 201 vs 200.
    cyc(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hC9, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hC8, 1'b0, 1'b0);
    check("p5_max_price", {72'd0, price_of_all[39:32]}, {72'd0, 8'hC8});
    idle(1, 1'b0);

    // Timeout after 16 idle edges, then 0x50 is a product byte again.
    cyc(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
    idle(16, 1'b0);
    cyc(1'b0, 1'b1, 8'h50, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Clear-all beats a simultaneous byte.
    cyc(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h0A, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h04, 1'b1, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (busy) busy_cnt++;
    end
    check("clear_busy_len", 80'(busy_cnt), 80'd9);
    check("clear_table", price_of_all, 80'd0);

    // Lock blocks commit and clear; reset abandons a clear.
    cyc(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(2, 1'b0);
    check("lock_table", {72'd0, price_of_all[15:8]}, {72'd0, 8'h22});
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(3, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_mid_clear_table", price_of_all, 80'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic.
    lk = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      bit r, v, c;
      logic [7:0] d;
      if ($urandom_range(0, 19) == 0) lk = ~lk;
      if ($urandom_range(0, 59) == 0) begin
        idle(17, lk);
      end else begin
        r = ($urandom_range(0, 299) == 0);
        c = ($urandom_range(0, 39) == 0);
        v = ($urandom_range(0, 9) < 6);
        case ($urandom_range(0, 3))
          0: d = 8'($urandom_range(0, 12));
          1: d = 8'($urandom_range(195, 205));
          default: d = 8'($urandom_range(0, 255));
        endcase
        cyc(r, v, d, c, lk);
      end
    end

    idle(14, 1'b0);
    check("leftover_events", 80'(exp_q.size()), 80'd0);
    check("final_table", price_of_all, pack_tbl());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
